// File: rtl/ahb_sram_pkg.sv
// ============================================================================
// Module   : ahb_sram_pkg
// Purpose  : Shared AHB constants, error-FSM encodings and lane decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_sram_pkg;

  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_busy   = 2'b01;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;
  localparam logic [1:0] c_htrans_seq    = 2'b11;

  localparam logic [2:0] c_hsize_byte = 3'd0;
  localparam logic [2:0] c_hsize_half = 3'd1;
  localparam logic [2:0] c_hsize_word = 3'd2;

  localparam int                c_st_w    = 2;
  localparam logic [c_st_w-1:0] c_st_okay = 2'd0;
  localparam logic [c_st_w-1:0] c_st_err1 = 2'd1;
  localparam logic [c_st_w-1:0] c_st_err2 = 2'd2;

  // Little-endian byte-lane enables for a transfer of the given size.
  function automatic logic [3:0] ben_decode(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] ben;
    case (hsize)
      c_hsize_byte: ben = 4'b0001 << addr;
      c_hsize_half: ben = addr[1] ? 4'b1100 : 4'b0011;
      default:      ben = 4'b1111;
    endcase
    return ben;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_sram_bridge_wbuf.sv
// ============================================================================
// Module   : ahb_sram_bridge_wbuf
// Purpose  : One-entry posted write buffer with per-lane read-data merge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_sram_bridge_wbuf #(
  parameter int MDW = 32,
  parameter int MAW = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic [MAW-3:0]     cap_waddr,
  input  logic [MDW-1:0]     cap_data,
  input  logic [MDW/8-1:0]   cap_ben,
  input  logic               drain,
  input  logic [MAW-3:0]     cmp_waddr,
  input  logic [MDW-1:0]     ramdout,
  output logic               wb_valid,
  output logic [MAW-3:0]     wb_waddr,
  output logic [MDW-1:0]     wb_data,
  output logic [MDW/8-1:0]   wb_ben,
  output logic [MDW-1:0]     rd_data
);

  logic               r_valid;
  logic [MAW-3:0]     r_waddr;
  logic [MDW-1:0]     r_data;
  logic [MDW/8-1:0]   r_ben;
  logic               w_hit;

  // A capture wins over a drain at the same edge: the old entry leaves, the new one lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_waddr <= '0;
      r_data  <= '0;
      r_ben   <= '0;
    end else begin
      r_valid <= capture | (r_valid & ~drain);
      if (capture) begin
        r_waddr <= cap_waddr;
        r_data  <= cap_data;
        r_ben   <= cap_ben;
      end
    end
  end

  assign w_hit = r_valid & (r_waddr == cmp_waddr);

  for (genvar i = 0; i < MDW/8; i++) begin : g_lane
    assign rd_data[8*i +: 8] = (w_hit & r_ben[i]) ? r_data[8*i +: 8] : ramdout[8*i +: 8];
  end

  assign wb_valid = r_valid;
  assign wb_waddr = r_waddr;
  assign wb_data  = r_data;
  assign wb_ben   = r_ben;

endmodule

`default_nettype wire

// File: rtl/ahb_sram_bridge.sv
// ============================================================================
// Module   : ahb_sram_bridge
// Purpose  : AHB-Lite slave to single-port SRAM, zero-wait reads, posted writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_sram_bridge
  import ahb_sram_pkg::*;
#(
  parameter int MDW = 32,
  parameter int MAW = 32,
  parameter int MAM = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           hsel,
  input  logic [MAW-1:0] haddr,
  input  logic [1:0]     htrans,
  input  logic [2:0]     hsize,
  input  logic           hwrite,
  input  logic [MDW-1:0] hwdata,
  input  logic           hready,
  output logic           hreadyout,
  output logic           hresp,
  output logic [MDW-1:0] hrdata,
  output logic           ramcs_n,
  output logic [MAW-1:0] ramaddr,
  output logic [MDW-1:0] ramdin,
  output logic [3:0]     ramben,
  output logic           ramwr_n,
  input  logic [MDW-1:0] ramdout
);

  localparam logic [MAW:0] c_limit = (MAW+1)'(MAM * 4);

  logic              w_active, w_aligned, w_valid, w_ok, w_rd_req, w_drain, w_capture;
  logic              r_dp_rd, r_dp_wr;
  logic [MAW-3:0]    r_dp_waddr;
  logic [3:0]        r_dp_ben;
  logic [c_st_w-1:0] r_state, w_state_next;
  logic              w_wb_valid;
  logic [MAW-3:0]    w_wb_waddr;
  logic [MDW-1:0]    w_wb_data, w_merged;
  logic [3:0]        w_wb_ben;

  always_comb begin
    w_active = 1'b0;
    case (htrans)
      c_htrans_nonseq, c_htrans_seq: w_active = 1'b1;
      c_htrans_idle, c_htrans_busy:  w_active = 1'b0;
      default:                       w_active = 1'b0;
    endcase
  end

  always_comb begin
    w_aligned = 1'b1;
    if (hsize == c_hsize_half)      w_aligned = ~haddr[0];
    else if (hsize == c_hsize_word) w_aligned = (haddr[1:0] == 2'b00);
  end

  assign w_valid   = hsel & w_active & hready;
  assign w_ok      = w_valid & ({1'b0, haddr} < c_limit) & w_aligned & (hsize <= c_hsize_word);
  assign w_rd_req  = w_ok & ~hwrite;
  // The buffer only gets the port in cycles without a read address phase.
  assign w_drain   = w_wb_valid & ~w_rd_req & ~rst;
  assign w_capture = r_dp_wr & hready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp_rd    <= 1'b0;
      r_dp_wr    <= 1'b0;
      r_dp_waddr <= '0;
      r_dp_ben   <= '0;
    end else if (hready) begin
      r_dp_rd    <= w_ok & ~hwrite;
      r_dp_wr    <= w_ok & hwrite;
      r_dp_waddr <= w_ok ? haddr[MAW-1:2] : '0;
      r_dp_ben   <= w_ok ? ben_decode(hsize, haddr[1:0]) : 4'b0000;
    end
  end

  ahb_sram_bridge_wbuf #(
    .MDW (MDW),
    .MAW (MAW)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .capture   (w_capture),
    .cap_waddr (r_dp_waddr),
    .cap_data  (hwdata),
    .cap_ben   (r_dp_ben),
    .drain     (w_drain),
    .cmp_waddr (r_dp_waddr),
    .ramdout   (ramdout),
    .wb_valid  (w_wb_valid),
    .wb_waddr  (w_wb_waddr),
    .wb_data   (w_wb_data),
    .wb_ben    (w_wb_ben),
    .rd_data   (w_merged)
  );

  assign hrdata = r_dp_rd ? w_merged : '0;

  always_comb begin
    ramcs_n = 1'b1;
    ramwr_n = 1'b1;
    ramaddr = '0;
    ramdin  = '0;
    ramben  = 4'b0000;
    if (rst) begin
      ramcs_n = 1'b1;
    end else if (w_rd_req) begin
      ramcs_n = 1'b0;
      ramaddr = {haddr[MAW-1:2], 2'b00};
      ramben  = 4'b1111;
    end else if (w_wb_valid) begin
      ramcs_n = 1'b0;
      ramwr_n = 1'b0;
      ramaddr = {w_wb_waddr, 2'b00};
      ramdin  = w_wb_data;
      ramben  = w_wb_ben;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_okay;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_okay: if (w_valid && !w_ok) w_state_next = c_st_err1;
      c_st_err1: w_state_next = c_st_err2;
      c_st_err2: w_state_next = (w_valid && !w_ok) ? c_st_err1 : c_st_okay;
      default:   w_state_next = c_st_okay;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (r_state)
      c_st_err1: begin hreadyout = 1'b0; hresp = 1'b1; end
      c_st_err2: hresp = 1'b1;
      default:   ;
    endcase
  end

  // A write data phase must never end while an undrained entry still occupies the buffer.
  a_wb_no_overwrite: assert property (@(posedge clk) disable iff (rst)
    (r_dp_wr && hready) |-> (!w_wb_valid || w_drain));

endmodule

`default_nettype wire
